// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RV32I instruction decode stage with register scoreboard.
//
// Decodes the fetched instruction, reads the register file (combinational
// read, addresses driven straight from the instruction bits), checks
// read-after-write and write-after-write hazards against a pending-write
// scoreboard and against the instruction currently held on the output, and
// registers the decoded payload for the execute stage.
//
// Ports
//   clk, rst_n                  pipeline clock, asynchronous active-low reset
//   in_valid/in_ready           fetch-side handshake
//   in_instr, in_pc             instruction word and its PC
//   rs1_addr/rs2_addr           register-file read addresses (always driven)
//   rs1_data/rs2_data           register-file read data (x0 reads 0)
//   wb_valid, wb_rd_addr        writeback retire strobe and destination
//   flush                       drop held output and refuse input this cycle
//   out_valid/out_ready         execute-side handshake
//   out_pc .. out_illegal       registered decoded payload
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd_addr,
  output logic        out_rd_we,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_s;
  logic        use_rs1_s;
  logic        use_rs2_s;
  logic        rd_we_raw_s;
  logic        rd_we_s;
  logic        illegal_s;
  logic        hazard_s;
  logic        accept_s;
  logic        xfer_s;
  logic [31:0] sb_set_s;
  logic [31:0] sb_clr_s;
  logic [31:0] sb_nxt_s;
  logic [31:0] sb_r;

  // A register is busy if a write to it is pending in the scoreboard or the
  // instruction sitting on the output (not yet transferred) will write it.
  function automatic logic reg_busy(
    input logic [4:0]  addr,
    input logic [31:0] sb,
    input logic        held_valid,
    input logic        held_we,
    input logic [4:0]  held_rd
  );
    reg_busy = sb[addr] || (held_valid && held_we && (held_rd == addr));
  endfunction

  assign opcode_s = in_instr[6:0];
  assign rd_s     = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // Format decode: immediate, source usage, write-enable and legality.
  always_comb begin
    imm_s       = 32'd0;
    use_rs1_s   = 1'b0;
    use_rs2_s   = 1'b0;
    rd_we_raw_s = 1'b0;
    illegal_s   = 1'b0;
    case (opcode_s)
      OP_R: begin
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
        rd_we_raw_s = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_s       = {{20{in_instr[31]}}, in_instr[31:20]};
        use_rs1_s   = 1'b1;
        rd_we_raw_s = 1'b1;
      end
      OP_STORE: begin
        imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_s     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_s       = {in_instr[31:12], 12'd0};
        rd_we_raw_s = 1'b1;
      end
      OP_JAL: begin
        imm_s       = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
        rd_we_raw_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Writes to x0 are dropped so they never occupy the scoreboard.
  assign rd_we_s = rd_we_raw_s && (rd_s != 5'd0);

  // Illegal instructions use no sources and never write, so they never stall.
  assign hazard_s =
      (use_rs1_s && reg_busy(rs1_addr, sb_r, out_valid, out_rd_we, out_rd_addr)) ||
      (use_rs2_s && reg_busy(rs2_addr, sb_r, out_valid, out_rd_we, out_rd_addr)) ||
      (rd_we_s   && reg_busy(rd_s,     sb_r, out_valid, out_rd_we, out_rd_addr));

  assign in_ready = (!out_valid || out_ready) && !hazard_s && !flush;
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid && out_ready && !flush;

  // Set beats clear on the same index; bit 0 is never pending.
  assign sb_set_s = (xfer_s && out_rd_we) ? (32'd1 << out_rd_addr) : 32'd0;
  assign sb_clr_s = wb_valid ? (32'd1 << wb_rd_addr) : 32'd0;
  assign sb_nxt_s = ((sb_r & ~sb_clr_s) | sb_set_s) & ~32'd1;

  // Scoreboard of destinations handed downstream but not yet written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= 32'd0;
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

  // Output valid: flush wins, then a new accept, then a plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
    end else if (xfer_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Output payload is loaded only on accept and otherwise held stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc       <= 32'd0;
      out_rs1_val  <= 32'd0;
      out_rs2_val  <= 32'd0;
      out_imm      <= 32'd0;
      out_rd_addr  <= 5'd0;
      out_rd_we    <= 1'b0;
      out_opcode   <= 7'd0;
      out_funct3   <= 3'd0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (accept_s) begin
      out_pc       <= in_pc;
      out_rs1_val  <= use_rs1_s ? rs1_data : 32'd0;
      out_rs2_val  <= use_rs2_s ? rs2_data : 32'd0;
      out_imm      <= imm_s;
      out_rd_addr  <= rd_s;
      out_rd_we    <= rd_we_s;
      out_opcode   <= opcode_s;
      out_funct3   <= in_instr[14:12];
      out_funct7b5 <= in_instr[30];
      out_illegal  <= illegal_s;
    end else begin
      out_pc       <= out_pc;
      out_rs1_val  <= out_rs1_val;
      out_rs2_val  <= out_rs2_val;
      out_imm      <= out_imm;
      out_rd_addr  <= out_rd_addr;
      out_rd_we    <= out_rd_we;
      out_opcode   <= out_opcode;
      out_funct3   <= out_funct3;
      out_funct7b5 <= out_funct7b5;
      out_illegal  <= out_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed testbench for id_stage.
//
// The register file is a combinational model: x0 reads 0, xN reads
// 32'hA5A5_0000 | N. Inputs change 1 ns after the rising edge; outputs are
// checked 1 ns after inputs change, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd_addr  (out_rd_addr),
        .out_rd_we    (out_rd_we),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_illegal  (out_illegal)
    );

    // Free-running clock initialisation.
    initial clk = 1'b0;
    // Clock toggle.
    always #5 clk = ~clk;

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : (32'hA5A5_0000 | {27'd0, rs1_addr});
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : (32'hA5A5_0000 | {27'd0, rs2_addr});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        if (obs !== exp_v) begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Directed stimulus and checks.
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = 32'h0010_8133;
        in_pc      = 32'd0;
        wb_valid   = 1'b0;
        wb_rd_addr = 5'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #2;
        // Reset state and address pass-through.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_rd_we", out_rd_we, 1'b0);
        check("rst_sb", dut.sb_r, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rs1_addr_add", rs1_addr, 5'd1);
        check("rs2_addr_add", rs2_addr, 5'd1);
        in_instr = 32'hFE53_2E23;
        #1;
        check("rs1_addr_sw", rs1_addr, 5'd6);
        check("rs2_addr_sw", rs2_addr, 5'd5);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // addi x1,x0,5 accepted with one cycle latency.
        in_instr  = 32'h0050_0093;
        in_pc     = 32'h0000_0100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("addi_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("addi_out_valid", out_valid, 1'b1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_rd", out_rd_addr, 5'd1);
        check("addi_rd_we", out_rd_we, 1'b1);
        check("addi_pc", out_pc, 32'h0000_0100);
        check("addi_rs1_val", out_rs1_val, 32'd0);
        check("addi_rs2_val", out_rs2_val, 32'd0);
        check("addi_opcode", out_opcode, 7'h13);
        tick();
        check("addi_sb1", dut.sb_r[1], 1'b1);
        check("addi_drained", out_valid, 1'b0);

        // add x2,x1,x1 stalls until one cycle after the x1 writeback.
        in_instr = 32'h0010_8133;
        in_pc    = 32'h0000_0104;
        in_valid = 1'b1;
        #1;
        check("raw_stall0", in_ready, 1'b0);
        tick();
        check("raw_stall1", in_ready, 1'b0);
        check("raw_no_out", out_valid, 1'b0);
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd1;
        #1;
        check("raw_stall_wb_cycle", in_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("raw_released", in_ready, 1'b1);
        tick();
        check("add_out_valid", out_valid, 1'b1);
        check("add_rs1_val", out_rs1_val, 32'hA5A5_0001);
        check("add_rs2_val", out_rs2_val, 32'hA5A5_0001);
        check("add_rd", out_rd_addr, 5'd2);
        check("add_imm", out_imm, 32'd0);

        // Backpressure holds payload; release gives back-to-back transfer.
        out_ready = 1'b0;
        in_instr  = 32'h0070_0193;
        in_pc     = 32'h0000_0108;
        in_valid  = 1'b1;
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        tick();
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_rd", out_rd_addr, 5'd2);
        check("bp_hold_pc", out_pc, 32'h0000_0104);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_rd", out_rd_addr, 5'd3);
        check("b2b_imm", out_imm, 32'd7);
        check("b2b_sb2", dut.sb_r[2], 1'b1);

        // Flush drops held addi x3 but still performs the x2 writeback clear.
        flush      = 1'b1;
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd2;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        flush    = 1'b0;
        wb_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_sb3", dut.sb_r[3], 1'b0);
        check("flush_wb_sb2", dut.sb_r[2], 1'b0);
        in_instr = 32'h0031_82B3;
        in_pc    = 32'h0000_010C;
        in_valid = 1'b1;
        #1;
        check("after_flush_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("x5_out_valid", out_valid, 1'b1);
        check("x5_rs1_val", out_rs1_val, 32'hA5A5_0003);
        check("x5_rd", out_rd_addr, 5'd5);
        tick();
        check("x5_sb5_set", dut.sb_r[5], 1'b1);
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd5;
        tick();
        wb_valid = 1'b0;
        check("x5_sb5_clr", dut.sb_r[5], 1'b0);

        // Store, illegal, lui x0, branch and jal immediates.
        in_instr = 32'hFE53_2E23;
        in_pc    = 32'h0000_0200;
        in_valid = 1'b1;
        #1;
        check("sw_ready", in_ready, 1'b1);
        tick();
        check("sw_imm", out_imm, 32'hFFFF_FFFC);
        check("sw_rd_we", out_rd_we, 1'b0);
        check("sw_rs1_val", out_rs1_val, 32'hA5A5_0006);
        check("sw_rs2_val", out_rs2_val, 32'hA5A5_0005);
        check("sw_funct3", out_funct3, 3'd2);
        in_instr = 32'hFFFF_FFFF;
        #1;
        check("ill_ready", in_ready, 1'b1);
        tick();
        check("ill_flag", out_illegal, 1'b1);
        check("ill_rd_we", out_rd_we, 1'b0);
        check("ill_imm", out_imm, 32'd0);
        check("ill_rs1_val", out_rs1_val, 32'd0);
        check("ill_f7b5", out_funct7b5, 1'b1);
        in_instr = 32'h1234_5037;
        tick();
        check("lui0_rd_we", out_rd_we, 1'b0);
        check("lui0_imm", out_imm, 32'h1234_5000);
        check("lui0_legal", out_illegal, 1'b0);
        in_instr = 32'hFE20_8FE3;
        tick();
        check("beq_imm", out_imm, 32'hFFFF_FFFE);
        check("beq_rd_we", out_rd_we, 1'b0);
        in_instr = 32'h0080_03EF;
        tick();
        check("jal_imm", out_imm, 32'd8);
        check("jal_rd_we", out_rd_we, 1'b1);
        check("jal_rd", out_rd_addr, 5'd7);

        // Set beats clear for x4 in the same cycle.
        in_instr = 32'h0010_0213;
        tick();
        in_valid = 1'b0;
        check("x4_held", out_rd_addr, 5'd4);
        check("jal_sb7", dut.sb_r[7], 1'b1);
        wb_valid   = 1'b1;
        wb_rd_addr = 5'd4;
        tick();
        wb_valid = 1'b0;
        check("set_wins_sb4", dut.sb_r[4], 1'b1);
        check("x4_drained", out_valid, 1'b0);

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        in_instr  = 32'h0070_0193;
        in_pc     = 32'h0000_0300;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_sb", dut.sb_r, 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
